counter_seq: RTL and testbench

- Single-shot sequence counter that times fixed-length events such as shifting out a 48-bit command or capturing an R1/R2 response.
- A one-cycle start strobe launches a count from 1 up to a programmable maximum.
- On reaching the maximum it emits a one-cycle done strobe and returns to idle (count 0).
- Used by the SD-card command serializer; idle is detected externally as cntr == 0.

---
 rtl/counter_seq_if.sv | 31 +++
 rtl/counter_seq.sv | 95 +++++++++
 tb/tb_counter_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_if.sv
// ----------------------------------------------------------------------------
// counter_seq_if
//   Control/status bundle between a sequencer (master) and counter_seq (slave).
//   Signals:
//     enable     master -> slave  count enable; low freezes the counter
//     start_strb master -> slave  one-cycle pulse launching a count sequence
//     cntr       slave  -> master current count (0 when idle), registered
//     strb       slave  -> master one-cycle completion pulse, registered
// ----------------------------------------------------------------------------
interface counter_seq_if #(
   parameter int unsigned dw = 8
);
   logic          enable;
   logic          start_strb;
   logic [dw-1:0] cntr;
   logic          strb;

   modport master (
      output enable,
      output start_strb,
      input  cntr,
      input  strb
   );

   modport slave (
      input  enable,
      input  start_strb,
      output cntr,
      output strb
   );
endinterface : counter_seq_if

// File: rtl/counter_seq.sv
// ----------------------------------------------------------------------------
// counter_seq
//   Single-shot sequence counter. A start pulse while idle launches a count
//   1, 2, ... max; the edge after reaching max returns the count to 0 and
//   raises strb for one cycle. Idle is recognised externally as cntr == 0.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset, clears all state
//     bus    counter_seq_if.slave (enable, start_strb in; cntr, strb out)
//   Parameters:
//     dw     counter width in bits (>= 2)
//     max    terminal count, must fit in dw bits; 0 gives an immediate strb
// ----------------------------------------------------------------------------
module counter_seq #(
   parameter int unsigned   dw  = 8,
   parameter logic [dw-1:0] max = 8'h2F
) (
   input  logic                clk,
   input  logic                reset,
   counter_seq_if.slave        bus
);

   localparam logic [dw-1:0] ZERO_C = {dw{1'b0}};
   localparam logic [dw-1:0] ONE_C  = {{(dw-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [dw-1:0] cntr_q,  cntr_d;
   logic          strb_q,  strb_d;

   // Next-state logic: strb is a pulse, so it defaults low every cycle.
   always_comb begin
      state_d = state_q;
      cntr_d  = cntr_q;
      strb_d  = 1'b0;
      if (bus.enable) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start_strb) begin
                  if (max == ZERO_C) begin
                     // Zero-length sequence: complete at once, stay idle.
                     strb_d = 1'b1;
                     cntr_d = ZERO_C;
                  end else begin
                     state_d = ST_RUN;
                     cntr_d  = ONE_C;
                  end
               end else begin
                  cntr_d = ZERO_C;
               end
            end
            ST_RUN: begin
               // start_strb is deliberately not examined here: retriggers
               // and a start coincident with the terminal edge are dropped.
               if (cntr_q == max) begin
                  strb_d  = 1'b1;
                  cntr_d  = ZERO_C;
                  state_d = ST_IDLE;
               end else begin
                  cntr_d = cntr_q + ONE_C;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cntr_d  = ZERO_C;
            end
         endcase
      end else begin
         // Frozen: hold count and state, start pulses are not remembered.
         state_d = state_q;
         cntr_d  = cntr_q;
      end
   end

   // State registers with asynchronous clear; an aborted sequence never strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cntr_q  <= ZERO_C;
         strb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         strb_q  <= strb_d;
      end
   end

   assign bus.cntr = cntr_q;
   assign bus.strb = strb_q;

endmodule : counter_seq

// File: tb/tb_counter_seq.sv
// ----------------------------------------------------------------------------
// tb_counter_seq
//   Seven counter_seq instances, one per terminal count of interest, sharing
//   clock and reset. A reference model derives the expected count from the
//   number of enabled edges elapsed since the accepted start.
// ----------------------------------------------------------------------------
module tb_counter_seq;

   localparam int NI = 7;
   localparam logic [7:0] MAXES [0:NI-1] = '{8'h31, 8'h2C, 8'h84, 8'h2F, 8'h03, 8'h00, 8'h01};

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NI-1:0]    en = '0;
   logic [NI-1:0]    st = '0;
   logic [7:0]       cntr_a [0:NI-1];
   logic [NI-1:0]    strb_a;

   int n_cmp  = 0;
   int n_fail = 0;

   // model: enabled-edge index, index of accepted start (-1 idle), expectations
   int   m_t;
   int   m_s;
   int   exp_cntr;
   logic exp_strb;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gen_dut
      counter_seq_if #(.dw(8)) bus ();
      assign bus.enable     = en[g];
      assign bus.start_strb = st[g];
      assign cntr_a[g]      = bus.cntr;
      assign strb_a[g]      = bus.strb;
      counter_seq #(.dw(8), .max(MAXES[g])) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus.slave)
      );
   end

   task automatic model_clear();
      m_t = 0; m_s = -1; exp_cntr = 0; exp_strb = 1'b0;
   endtask

   // Drive one cycle on instance idx and advance the model; returns #1 after edge.
   task automatic tick(input int idx, input logic e, input logic s);
      int d;
      int mx;
      mx = int'(MAXES[idx]);
      en[idx] = e;
      st[idx] = s;
      @(posedge clk);
      if (e) begin
         m_t++;
         if (m_s < 0 && s) m_s = m_t;
         if (m_s >= 0) begin
            d = m_t - m_s;
            if (d < mx) begin
               exp_cntr = d + 1; exp_strb = 1'b0;
            end else begin
               exp_cntr = 0; exp_strb = 1'b1; m_s = -1;
            end
         end else begin
            exp_cntr = 0; exp_strb = 1'b0;
         end
      end else begin
         exp_strb = 1'b0;
      end
      #1;
      st[idx] = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (cntr_a[i] !== 8'h00 || strb_a[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state inst=%0d cntr=%h strb=%b expected cntr=00 strb=0", i, cntr_a[i], strb_a[i]);
         end
      end
      en = '1; st = '1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (cntr_a[i] !== 8'h00 || strb_a[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold inst=%0d cntr=%h strb=%b expected cntr=00 strb=0", i, cntr_a[i], strb_a[i]);
         end
      end
      en = '0; st = '0;
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_basic();
      int edges;
      model_clear();
      repeat ($urandom_range(0, 5)) tick(0, 1'b1, 1'b0);
      tick(0, 1'b1, 1'b1);
      edges = 1;
      for (int k = 0; k < 200; k++) begin
         n_cmp++;
         if (cntr_a[0] !== 8'(exp_cntr) || strb_a[0] !== exp_strb) begin
            n_fail++;
            $display("FAIL basic edge=%0d cntr=%h strb=%b expected cntr=%h strb=%b", edges, cntr_a[0], strb_a[0], 8'(exp_cntr), exp_strb);
         end
         if (strb_a[0] === 1'b1) break;
         tick(0, 1'b1, 1'b0);
         edges++;
      end
      n_cmp++;
      if (edges != 50) begin
         n_fail++;
         $display("FAIL basic_latency strb after %0d edges expected 50", edges);
      end
      repeat (3) begin
         tick(0, 1'b1, 1'b0);
         n_cmp++;
         if (cntr_a[0] !== 8'h00 || strb_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle cntr=%h strb=%b expected cntr=00 strb=0", cntr_a[0], strb_a[0]);
         end
      end
   endtask

   task automatic test_enable_pause();
      int edges;
      model_clear();
      tick(1, 1'b1, 1'b1);
      edges = 1;
      for (int k = 0; k < 200; k++) begin
         if (exp_cntr == 10) begin
            repeat (5) begin
               tick(1, 1'b0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
               edges++;
               n_cmp++;
               if (cntr_a[1] !== 8'd10 || strb_a[1] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL pause_hold cntr=%h strb=%b expected cntr=0a strb=0", cntr_a[1], strb_a[1]);
               end
            end
         end
         tick(1, 1'b1, 1'b0);
         edges++;
         n_cmp++;
         if (cntr_a[1] !== 8'(exp_cntr) || strb_a[1] !== exp_strb) begin
            n_fail++;
            $display("FAIL pause edge=%0d cntr=%h strb=%b expected cntr=%h strb=%b", edges, cntr_a[1], strb_a[1], 8'(exp_cntr), exp_strb);
         end
         if (strb_a[1] === 1'b1) break;
      end
      n_cmp++;
      if (edges != 50) begin
         n_fail++;
         $display("FAIL pause_latency strb after %0d edges expected 50", edges);
      end
   endtask

   task automatic test_retrigger();
      int edges;
      int nstrb;
      logic s;
      model_clear();
      tick(2, 1'b1, 1'b1);
      edges = 1;
      nstrb = 0;
      for (int k = 0; k < 300 && nstrb == 0; k++) begin
         s = (exp_cntr == 20 || $urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
         tick(2, 1'b1, s);
         edges++;
         n_cmp++;
         if (cntr_a[2] !== 8'(exp_cntr) || strb_a[2] !== exp_strb) begin
            n_fail++;
            $display("FAIL retrigger edge=%0d cntr=%h strb=%b expected cntr=%h strb=%b", edges, cntr_a[2], strb_a[2], 8'(exp_cntr), exp_strb);
         end
         if (strb_a[2] === 1'b1) nstrb++;
      end
      n_cmp++;
      if (edges != 133) begin
         n_fail++;
         $display("FAIL retrigger_latency strb after %0d edges expected 133", edges);
      end
      repeat (4) begin
         tick(2, 1'b1, 1'b0);
         n_cmp++;
         if (cntr_a[2] !== 8'h00 || strb_a[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL retrigger_idle cntr=%h strb=%b expected cntr=00 strb=0", cntr_a[2], strb_a[2]);
         end
      end
   endtask

   task automatic test_async_reset();
      model_clear();
      tick(3, 1'b1, 1'b1);
      for (int k = 0; k < 100 && exp_cntr != 30; k++) tick(3, 1'b1, 1'b0);
      n_cmp++;
      if (cntr_a[3] !== 8'd30) begin
         n_fail++;
         $display("FAIL areset_pre cntr=%h expected 1e", cntr_a[3]);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (cntr_a[3] !== 8'h00 || strb_a[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_immediate cntr=%h strb=%b expected cntr=00 strb=0", cntr_a[3], strb_a[3]);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      model_clear();
      repeat (60) begin
         tick(3, 1'b1, 1'b0);
         n_cmp++;
         if (cntr_a[3] !== 8'h00 || strb_a[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_no_strb cntr=%h strb=%b expected cntr=00 strb=0", cntr_a[3], strb_a[3]);
         end
      end
      tick(3, 1'b1, 1'b1);
      n_cmp++;
      if (cntr_a[3] !== 8'h01 || strb_a[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_restart cntr=%h strb=%b expected cntr=01 strb=0", cntr_a[3], strb_a[3]);
      end
      while (exp_cntr != 0) tick(3, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int edges;
      model_clear();
      tick(4, 1'b1, 1'b1);
      edges = 1;
      // first sequence, restart right after strb, then start on terminal edge
      for (int k = 0; k < 20; k++) begin
         tick(4, 1'b1, (edges == 4 || edges == 7) ? 1'b1 : 1'b0);
         edges++;
         n_cmp++;
         if (cntr_a[4] !== 8'(exp_cntr) || strb_a[4] !== exp_strb) begin
            n_fail++;
            $display("FAIL back_to_back edge=%0d cntr=%h strb=%b expected cntr=%h strb=%b", edges, cntr_a[4], strb_a[4], 8'(exp_cntr), exp_strb);
         end
      end
      n_cmp++;
      if (exp_cntr != 0 || m_s != -1) begin
         n_fail++;
         $display("FAIL back_to_back_model_idle cntr=%0d expected 0", exp_cntr);
      end
   endtask

   task automatic test_edge_params();
      model_clear();
      tick(5, 1'b1, 1'b1);
      n_cmp++;
      if (cntr_a[5] !== 8'h00 || strb_a[5] !== 1'b1) begin
         n_fail++;
         $display("FAIL max0_strb cntr=%h strb=%b expected cntr=00 strb=1", cntr_a[5], strb_a[5]);
      end
      tick(5, 1'b1, 1'b0);
      n_cmp++;
      if (cntr_a[5] !== 8'h00 || strb_a[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL max0_after cntr=%h strb=%b expected cntr=00 strb=0", cntr_a[5], strb_a[5]);
      end
      model_clear();
      tick(6, 1'b1, 1'b1);
      n_cmp++;
      if (cntr_a[6] !== 8'h01 || strb_a[6] !== 1'b0) begin
         n_fail++;
         $display("FAIL max1_count cntr=%h strb=%b expected cntr=01 strb=0", cntr_a[6], strb_a[6]);
      end
      tick(6, 1'b1, 1'b0);
      n_cmp++;
      if (cntr_a[6] !== 8'h00 || strb_a[6] !== 1'b1) begin
         n_fail++;
         $display("FAIL max1_strb cntr=%h strb=%b expected cntr=00 strb=1", cntr_a[6], strb_a[6]);
      end
   endtask

   task automatic test_random();
      int ids [4] = '{4, 5, 6, 1};
      int idx;
      logic e, s;
      for (int j = 0; j < 4; j++) begin
         idx = ids[j];
         model_clear();
         for (int k = 0; k < 250; k++) begin
            e = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            s = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            if (k >= 200) begin e = 1'b1; s = 1'b0; end
            tick(idx, e, s);
            n_cmp++;
            if (cntr_a[idx] !== 8'(exp_cntr) || strb_a[idx] !== exp_strb) begin
               n_fail++;
               $display("FAIL random inst=%0d cyc=%0d cntr=%h strb=%b expected cntr=%h strb=%b", idx, k, cntr_a[idx], strb_a[idx], 8'(exp_cntr), exp_strb);
            end
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_enable_pause();
      test_retrigger();
      test_async_reset();
      test_back_to_back();
      test_edge_params();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_counter_seq
